// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared types and constants for the ram_sdp_clr RAM family.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   function automatic int lane_count(input int data_w);
      return data_w / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sdp_clr_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sdp_clr_if
// Brief    : Write/read/clear bus of the simple-dual-port clearable RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_sdp_clr_if
   import ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   localparam int c_lanes = lane_count(DATA_W);

   logic                 clr_req;
   logic                 wr_en;
   logic [c_lanes-1:0]   wr_be;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   logic [DATA_W-1:0]    rd_data;
   logic                 rd_valid;
   logic                 busy;
   logic                 init_done;

   modport master (
      output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, busy, init_done
   );

   modport slave (
      input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, busy, init_done
   );

endinterface
`default_nettype wire

// File: rtl/ram_be_merge.sv
`default_nettype none
// ============================================================================
// Module   : ram_be_merge
// Brief    : Byte-lane merge of an old and a new word under a lane-enable mask.
// Revision : 1.0 - initial release
// ============================================================================
module ram_be_merge
   import ram_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]            i_old,
   input  logic [DATA_W-1:0]            i_new,
   input  logic [lane_count(DATA_W)-1:0] i_be,
   output logic [DATA_W-1:0]            o_merged
);

   generate
      for (genvar k = 0; k < lane_count(DATA_W); k++) begin : g_lane
         assign o_merged[8*k +: 8] = i_be[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ram_sdp_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_sdp_clr
// Brief    : Simple-dual-port RAM with byte enables, selectable read-during-
//            write behaviour and a sequenced full-memory clear.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sdp_clr
   import ram_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 4,
   parameter int                RDW_MODE = RDW_READ_FIRST,
   parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
   input  logic          clk,
   input  logic          rst,
   ram_sdp_clr_if.slave  bus
);

   localparam int               c_depth    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] c_cnt_last = {ADDR_W{1'b1}};

   logic [DATA_W-1:0] r_mem [c_depth];

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_init_done;

   logic              w_user_ok;
   logic              w_wr_fire;
   logic              w_rd_fire;
   logic [DATA_W-1:0] w_wr_word;
   logic [DATA_W-1:0] w_rd_word;

   always_comb begin
      w_state_nxt = r_state;
      w_user_ok   = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == c_cnt_last) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            // A clear request pre-empts any user access in the same cycle
            if (bus.clr_req) begin
               w_state_nxt = ST_CLEAR;
            end else begin
               w_user_ok = 1'b1;
            end
         end
      endcase
   end

   assign w_wr_fire = w_user_ok & bus.wr_en;
   assign w_rd_fire = w_user_ok & bus.rd_en;

   ram_be_merge #(
      .DATA_W (DATA_W)
   ) u_merge (
      .i_old    (r_mem[bus.wr_addr]),
      .i_new    (bus.wr_data),
      .i_be     (bus.wr_be),
      .o_merged (w_wr_word)
   );

   generate
      if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
         assign w_rd_word = (w_wr_fire && (bus.wr_addr == bus.rd_addr))
                          ? w_wr_word : r_mem[bus.rd_addr];
      end else begin : g_read_first
         assign w_rd_word = r_mem[bus.rd_addr];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_CLEAR;
         r_clr_cnt   <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= w_rd_fire;
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            if (r_clr_cnt == c_cnt_last) begin
               r_init_done <= 1'b1;
            end
         end else begin
            r_clr_cnt <= '0;
         end
         if (w_rd_fire) begin
            r_rd_data <= w_rd_word;
         end
      end
   end

   // Storage is left untouched while rst is held; the clear sequence follows.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= CLR_VAL;
         end else if (w_wr_fire) begin
            r_mem[bus.wr_addr] <= w_wr_word;
         end
      end
   end

   assign bus.rd_data   = r_rd_data;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.busy      = (r_state == ST_CLEAR);
   assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sdp_clr
// Brief    : Self-checking bench for ram_sdp_clr (8-bit read-first and
//            32-bit write-first instances) against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sdp_clr;
   import ram_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_sdp_clr_if #(.DATA_W(8),  .ADDR_W(4)) bus_a ();
   ram_sdp_clr_if #(.DATA_W(32), .ADDR_W(6)) bus_b ();

   ram_sdp_clr #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(RDW_READ_FIRST), .CLR_VAL(8'hA5))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   ram_sdp_clr #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(RDW_WRITE_FIRST), .CLR_VAL(32'hDEADBEEF))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int total = 0;
   int bad   = 0;

   logic        s_clr [2];
   logic        s_wen [2];
   logic        s_ren [2];
   logic [3:0]  s_be  [2];
   logic [5:0]  s_wa  [2];
   logic [5:0]  s_ra  [2];
   logic [31:0] s_wd  [2];

   assign bus_a.clr_req = s_clr[0];
   assign bus_a.wr_en   = s_wen[0];
   assign bus_a.wr_be   = s_be[0][0:0];
   assign bus_a.wr_addr = s_wa[0][3:0];
   assign bus_a.wr_data = s_wd[0][7:0];
   assign bus_a.rd_en   = s_ren[0];
   assign bus_a.rd_addr = s_ra[0][3:0];
   assign bus_b.clr_req = s_clr[1];
   assign bus_b.wr_en   = s_wen[1];
   assign bus_b.wr_be   = s_be[1];
   assign bus_b.wr_addr = s_wa[1];
   assign bus_b.wr_data = s_wd[1];
   assign bus_b.rd_en   = s_ren[1];
   assign bus_b.rd_addr = s_ra[1];

   // Reference model: one slot per instance
   int          m_lanes [2] = '{1, 4};
   int          m_depth [2] = '{16, 64};
   int          m_mode  [2] = '{0, 1};
   logic [31:0] m_clrv  [2] = '{32'h000000A5, 32'hDEADBEEF};
   logic [31:0] m_mem   [2][64];
   int          m_left  [2] = '{0, 0};
   logic        m_init  [2] = '{1'b0, 1'b0};
   logic        m_rv    [2] = '{1'b0, 1'b0};
   logic [31:0] m_rd    [2] = '{32'h0, 32'h0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be, input int lanes);
      logic [31:0] res = old_w;
      for (int k = 0; k < lanes; k++)
         if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      return res;
   endfunction

   task automatic model_step(input int d);
      logic [31:0] mrg;
      if (rst) begin
         m_left[d] = m_depth[d];
         m_init[d] = 1'b0;
         m_rv[d]   = 1'b0;
         m_rd[d]   = '0;
      end else if (m_left[d] > 0) begin
         m_mem[d][m_depth[d] - m_left[d]] = m_clrv[d];
         m_left[d]--;
         if (m_left[d] == 0) m_init[d] = 1'b1;
         m_rv[d] = 1'b0;
      end else if (s_clr[d]) begin
         m_left[d] = m_depth[d];
         m_rv[d]   = 1'b0;
      end else begin
         mrg = merge(m_mem[d][s_wa[d]], s_wd[d], s_be[d], m_lanes[d]);
         m_rv[d] = s_ren[d];
         if (s_ren[d])
            m_rd[d] = (m_mode[d] == 1 && s_wen[d] && s_wa[d] == s_ra[d]) ? mrg : m_mem[d][s_ra[d]];
         if (s_wen[d]) m_mem[d][s_wa[d]] = mrg;
      end
   endtask

   // Advance one clock, update the model and compare every output of both instances
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("a_busy",  32'(bus_a.busy),      32'(m_left[0] > 0));
      check("a_init",  32'(bus_a.init_done), 32'(m_init[0]));
      check("a_valid", 32'(bus_a.rd_valid),  32'(m_rv[0]));
      check("a_rdata", 32'(bus_a.rd_data),   m_rd[0]);
      check("b_busy",  32'(bus_b.busy),      32'(m_left[1] > 0));
      check("b_init",  32'(bus_b.init_done), 32'(m_init[1]));
      check("b_valid", 32'(bus_b.rd_valid),  32'(m_rv[1]));
      check("b_rdata", 32'(bus_b.rd_data),   m_rd[1]);
   endtask

   task automatic idle();
      for (int d = 0; d < 2; d++) begin
         s_clr[d] = 1'b0; s_wen[d] = 1'b0; s_ren[d] = 1'b0;
         s_be[d] = 4'h0; s_wa[d] = '0; s_ra[d] = '0; s_wd[d] = '0;
      end
   endtask

   // Run until both instances leave busy; report the cycle counts
   task automatic busy_len(output int na, output int nb);
      na = -1;
      nb = -1;
      for (int i = 1; i <= 100 && nb < 0; i++) begin
         tick();
         if (na < 0 && !bus_a.busy) na = i;
         if (nb < 0 && !bus_b.busy) nb = i;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int na, nb;
      idle();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      busy_len(na, nb);
      check("a_init_len", 32'(na), 32'd16);
      check("b_init_len", 32'(nb), 32'd64);

      // Every entry of the 8-bit instance reads back the clear value
      for (int a = 0; a < 16; a++) begin
         s_ren[0] = 1'b1; s_ra[0] = 6'(a);
         tick();
         check("a_clr_rd", 32'(bus_a.rd_data), 32'hA5);
         check("a_clr_valid", 32'(bus_a.rd_valid), 32'd1);
      end
      idle();
      tick();

      // Byte-lane writes on the 32-bit instance
      s_wen[1] = 1'b1; s_wa[1] = 6'd5; s_wd[1] = 32'h11223344; s_be[1] = 4'b1111;
      tick();
      s_wd[1] = 32'hAABBCCDD; s_be[1] = 4'b0101;
      tick();
      idle();
      s_ren[1] = 1'b1; s_ra[1] = 6'd5;
      tick();
      check("b_be_rd", bus_b.rd_data, 32'h11BB33DD);

      // Read-during-write on address 3
      idle();
      for (int d = 0; d < 2; d++) begin
         s_wen[d] = 1'b1; s_wa[d] = 6'd3; s_wd[d] = 32'h10; s_be[d] = 4'hF;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         s_wd[d] = 32'h20; s_ren[d] = 1'b1; s_ra[d] = 6'd3;
      end
      tick();
      check("a_rdw_old", 32'(bus_a.rd_data), 32'h10);
      check("b_rdw_new", bus_b.rd_data, 32'h20);
      for (int d = 0; d < 2; d++) s_wen[d] = 1'b0;
      tick();
      check("a_rdw_after", 32'(bus_a.rd_data), 32'h20);
      check("b_rdw_after", bus_b.rd_data, 32'h20);

      // Fill, then clear on request while writes and reads are attempted
      idle();
      for (int a = 0; a < 16; a++) begin
         s_wen[0] = 1'b1; s_wa[0] = 6'(a); s_wd[0] = 32'h3C; s_be[0] = 4'h1;
         tick();
      end
      s_clr[0] = 1'b1; s_wa[0] = 6'd1; s_wd[0] = 32'h77; s_ren[0] = 1'b1; s_ra[0] = 6'd1;
      tick();
      check("a_clr_start", 32'(bus_a.busy), 32'd1);
      s_clr[0] = 1'b0; s_wa[0] = 6'd0; s_wd[0] = 32'hFF; s_ra[0] = 6'd0;
      na = -1;
      for (int i = 1; i <= 40 && na < 0; i++) begin
         tick();
         check("a_init_hold", 32'(bus_a.init_done), 32'd1);
         if (!bus_a.busy) na = i;
      end
      check("a_clr_len", 32'(na), 32'd16);
      idle();
      for (int a = 0; a < 16; a++) begin
         s_ren[0] = 1'b1; s_ra[0] = 6'(a);
         tick();
         check("a_reclr_rd", 32'(bus_a.rd_data), 32'hA5);
      end

      // Reset in the middle of a clear restarts the sequence
      idle();
      s_clr[0] = 1'b1;
      tick();
      s_clr[0] = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check("a_rst_init", 32'(bus_a.init_done), 32'd0);
      check("a_rst_busy", 32'(bus_a.busy), 32'd1);
      rst = 1'b0;
      busy_len(na, nb);
      check("a_rst_len", 32'(na), 32'd16);
      check("b_rst_len", 32'(nb), 32'd64);

      // Random concurrent traffic on both instances
      for (int c = 0; c < 200; c++) begin
         for (int d = 0; d < 2; d++) begin
            s_clr[d] = 1'b0;
            s_wen[d] = 1'($urandom_range(0, 1));
            s_ren[d] = 1'($urandom_range(0, 1));
            s_be[d]  = 4'($urandom);
            s_wd[d]  = $urandom;
            s_wa[d]  = 6'($urandom_range(0, m_depth[d] - 1));
            s_ra[d]  = ($urandom_range(0, 3) == 0) ? s_wa[d]
                     : 6'($urandom_range(0, m_depth[d] - 1));
         end
         tick();
      end

      idle();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
